// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, types and helpers for the moving-sum FIR
//
// Purpose: common definitions imported by fir_ntap_pipe.
//   TAPS_MAX   : largest supported tap count
//   fill_cnt_t : warm-up fill counter type (7 bits, holds 0..TAPS_MAX)
//   fir_lg()   : number of adder-tree levels for a given tap count
package fir_pkg;

  localparam int TAPS_MAX = 64;
  localparam int FILL_W   = $clog2(TAPS_MAX + 1);

  typedef logic [FILL_W-1:0] fill_cnt_t;

  function automatic int fir_lg(input int taps);
    return $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_add_stage.sv
// rtl/fir_add_stage.sv - one registered level of the pairwise adder tree
//
// Purpose: adds PAIRS pairs of IN_W-bit operands into PAIRS registered
// (IN_W+1)-bit sums, with a valid tag travelling alongside.
// Ports:
//   clk       : clock
//   reset     : synchronous active-low reset
//   in_valid  : tag entering this level; sums load only when it is 1
//   in_data   : 2*PAIRS operands, operand n at [n*IN_W +: IN_W]
//   out_valid : registered tag
//   out_data  : PAIRS sums, sum p at [p*(IN_W+1) +: IN_W+1]
module fir_add_stage #(
  parameter int IN_W  = 16,
  parameter int PAIRS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [2*PAIRS*IN_W-1:0]     in_data,
  output logic                        out_valid,
  output logic [PAIRS*(IN_W+1)-1:0]   out_data
);

  logic [PAIRS*(IN_W+1)-1:0] sum_d, sum_q;
  logic                      vld_d, vld_q;

  always_comb begin
    sum_d = sum_q;
    vld_d = in_valid;
    if (in_valid) begin
      for (int p = 0; p < PAIRS; p++) begin
        sum_d[p*(IN_W+1) +: IN_W+1] = {1'b0, in_data[2*p*IN_W +: IN_W]}
                                    + {1'b0, in_data[(2*p+1)*IN_W +: IN_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = sum_q;

endmodule

// File: rtl/fir_ntap_pipe.sv
// rtl/fir_ntap_pipe.sv - pipelined TAPS-point moving sum (or rounded mean)
//
// Purpose: keeps a TAPS-deep delay line of accepted samples and sums it
// through a registered binary adder tree of LG = log2(TAPS) levels.
// Results appear only once the delay line has been filled after reset.
// Optional macro FIR_AVG_EN: output the rounded mean instead of the sum.
// Ports:
//   clk       : clock
//   reset     : synchronous active-low reset
//   in_valid  : a is accepted on a posedge where in_valid=1
//   a         : unsigned W-bit input sample
//   out_valid : s holds a new result this cycle
//   s         : W+LG-bit result (sum, or mean in s[W-1:0] when FIR_AVG_EN)
module fir_ntap_pipe
  import fir_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [W-1:0]              a,
  output logic                      out_valid,
  output logic [W+fir_lg(TAPS)-1:0] s
);

  localparam int        LG        = fir_lg(TAPS);
  localparam fill_cnt_t FILL_FULL = fill_cnt_t'(TAPS);

  logic [W-1:0]      dl_d [TAPS];
  logic [W-1:0]      dl_q [TAPS];
  fill_cnt_t         fill_d, fill_q;
  logic              tag_in;
  logic [TAPS*W-1:0] dl_flat;

  logic [W+LG-1:0]   sum;
  logic              sum_valid;
  logic [W+LG-1:0]   s_d, s_q;
  logic              out_valid_d, out_valid_q;

  // The first tree level is fed from the next-state delay line so that
  // its register loads on the same edge that accepts the sample; this keeps
  // the accept-to-result latency at exactly LG edges plus the output register.
  always_comb begin
    dl_d   = dl_q;
    fill_d = fill_q;
    if (in_valid) begin
      dl_d[0] = a;
      for (int j = 1; j < TAPS; j++) begin
        dl_d[j] = dl_q[j-1];
      end
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + fill_cnt_t'(1);
      end
    end
    tag_in = in_valid && (fill_d == FILL_FULL);
    for (int j = 0; j < TAPS; j++) begin
      dl_flat[j*W +: W] = dl_d[j];
    end
  end

  for (genvar i = 0; i < LG; i++) begin : g_lvl
    localparam int IW = W + i;
    localparam int P  = TAPS >> (i + 1);

    logic [2*P*IW-1:0] din;
    logic              vin;
    logic [P*(IW+1)-1:0] dout;
    logic              vout;

    if (i == 0) begin : g_src
      assign din = dl_flat;
      assign vin = tag_in;
    end else begin : g_chain
      assign din = g_lvl[i-1].dout;
      assign vin = g_lvl[i-1].vout;
    end

    fir_add_stage #(
      .IN_W  (IW),
      .PAIRS (P)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vin),
      .in_data   (din),
      .out_valid (vout),
      .out_data  (dout)
    );
  end

  assign sum       = g_lvl[LG-1].dout;
  assign sum_valid = g_lvl[LG-1].vout;

  // Rounded mean cannot overflow: TAPS*(2^W-1) + TAPS/2 < TAPS*2^W.
  always_comb begin
    s_d         = s_q;
    out_valid_d = sum_valid;
    if (sum_valid) begin
`ifdef FIR_AVG_EN
      s_d = (sum + (W+LG)'(TAPS/2)) >> LG;
`else
      s_d = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < TAPS; j++) begin
        dl_q[j] <= '0;
      end
      fill_q      <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int j = 0; j < TAPS; j++) begin
        dl_q[j] <= dl_d[j];
      end
      fill_q      <= fill_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;

endmodule

// File: doc/fir_ntap_pipe.md
FIR_NTAP_PIPE -- requirements
Module: fir_ntap_pipe

Interface
REQ-001 SHALL have parameter W, default 16, unsigned input sample width (4..32).
REQ-002 SHALL have parameter TAPS, default 4, moving-sum tap count; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  sample a is accepted on a posedge where in_valid=1.
REQ-006 SHALL have port a  input  W  unsigned input sample.
REQ-007 SHALL have port out_valid  output  1  s holds a new result for this cycle.
REQ-008 SHALL have port s  output  W+LG  result, where LG=log2(TAPS).

Function
REQ-009 SHALL hold a TAPS-deep delay line that shifts only on accepted samples: newest at index 0, oldest dropped.
REQ-010 SHALL compute the unsigned sum of all TAPS delay-line entries through a binary adder tree of LG levels; each level SHALL be registered.
REQ-011 SHALL widen each tree level by one bit. No overflow or truncation is possible; the maximum result is TAPS*(2^W-1).
REQ-012 SHALL carry a valid tag beside the data through every tree level; a level's registers SHALL load only when the tag entering that level is 1.
REQ-013 Latency: a sample accepted at edge k SHALL produce out_valid=1 with the corresponding s in the cycle after edge k+LG.
REQ-014 SHALL pulse out_valid exactly once per accepted sample after warm-up. Back-to-back accepts SHALL give back-to-back results (throughput one per cycle).
REQ-015 Warm-up: a 7-bit fill counter SHALL count accepts and saturate at TAPS. The valid tag SHALL be set only for accepts that make the counter reach or stay at TAPS.
REQ-016 Input bubbles (in_valid=0) SHALL NOT shift the delay line or the counter; they SHALL appear as out_valid=0 gaps.
REQ-017 While out_valid=0, s SHALL hold its last value.

Reset
REQ-018 With reset=0 at a posedge, the following SHALL be cleared to 0 at that edge regardless of in_valid: delay line, tree registers, valid tags, fill counter, s and out_valid.
REQ-019 Reset mid-stream SHALL discard all in-flight results. Warm-up SHALL restart, so the first out_valid after reset requires TAPS new accepts.
REQ-020 The first edge with reset=1 SHALL accept in_valid normally.

Configuration
REQ-021 Macro FIR_AVG_EN, when defined, SHALL make s = (sum + TAPS/2) >> LG, the rounded mean, in s[W-1:0], with s[W+LG-1:W]=0. Latency and handshake are unchanged.
REQ-022 Without FIR_AVG_EN, s SHALL be the full-width sum (REQ-011).

Structure
REQ-023 Package fir_pkg SHALL hold:
- TAPS_MAX=64
- function clog2-based LG helper
- typedef for the fill counter
REQ-024 Each tree level SHALL be one instance of sub-module fir_add_stage. It is parametrised by input width and pair count, and holds registered pairwise sums plus a valid tag.
REQ-025 The top level SHALL contain only the delay line, the fill counter, the generate loop of fir_add_stage, and the output register.

Verification (W=16, TAPS=4 unless stated)
REQ-026 Accept 1,2,3,4 on consecutive edges:
- out_valid first high 2 cycles after the accept of 4, with s=10.
- Then accept 5: s=14 on the next cycle.
REQ-027 Accept 0xFFFF for 6 consecutive edges: s=0x3FFFC on every valid result, with no wrap.
REQ-028 Accept 1,2, bubble 3 cycles, then accept 3,4: s=10 with a single out_valid pulse; no out_valid during the bubbles.
REQ-029 Accept 1..6, assert reset for 1 cycle, then accept 7,8,9: out_valid stays 0. Accept 10: s=34.
REQ-030 With FIR_AVG_EN, accept 1,2,3,4: s=3 (mean (10+2)>>2). Accept 0xFFFF x4: s=0xFFFF.
REQ-031 With TAPS=8, accept 1..8: out_valid appears 3 cycles after the accept of 8, with s=36.
